shared_mem_rr_scheduler: RTL

//  Multi-cycle round-robin scheduler for the 4-core shared data memory. Accepts per-core

---
 rtl/shared_mem_rr_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/shared_mem_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : shared_mem_rr_scheduler
// Purpose  : Multi-cycle round-robin scheduler for the 4-core shared data
//            memory. Picks one requesting core fairly, registers its
//            operands, holds the memory for ACC_CYCLES cycles, pulses done
//            for that core and stalls every other requester.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W      shared memory word-address width (mem_addr upper bits are 0)
//   ACC_CYCLES  cycles a granted access holds the memory (>= 1)
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   req[3:0]     in   per-core access request, held until done
//   rd_in/wd_in  in   per-core read / write command
//   addr_in      in   core i address at [32i+31:32i]
//   wdata_in     in   core i write data at [32i+31:32i]
//   lock[3:0]    in   per-core lock request (only with SHMEM_ARB_LOCK_EN)
//   mem_rdata    in   read data from shared memory
//   mem_addr     out  registered address to memory
//   mem_wdata    out  registered write data to memory
//   mem_rd/wd    out  memory read / write strobes
//   done[3:0]    out  one-hot completion pulse
//   stall[3:0]   out  req & ~done
//   rdata        out  mem_rdata passthrough
//   shared_busy  out  high while an access holds the memory
// Configuration macro
//   SHMEM_ARB_LOCK_EN : the current owner may extend with back-to-back
//                       accesses while it holds lock and req.
// ============================================================================
module shared_mem_rr_scheduler #(
    parameter int ADDR_W     = 7,
    parameter int ACC_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [3:0]   req,
    input  logic [3:0]   rd_in,
    input  logic [3:0]   wd_in,
    input  logic [127:0] addr_in,
    input  logic [127:0] wdata_in,
    input  logic [3:0]   lock,
    input  logic [31:0]  mem_rdata,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         mem_rd,
    output logic         mem_wd,
    output logic [3:0]   done,
    output logic [3:0]   stall,
    output logic [31:0]  rdata,
    output logic         shared_busy
);

    localparam int         C_CNT_W   = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(ACC_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [1:0]          r_ptr;
    logic [1:0]          r_grant;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_rd;
    logic                r_wd;

    logic [1:0]          w_win;
    logic                w_win_valid;
    logic [1:0]          w_src;
    logic [31:0]         w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic                w_last;
    logic                w_extend;

    // Round-robin pick: first set request scanning ptr+1, ptr+2, ... mod 4.
    // The scan ends on ptr itself so the last owner is considered last.
    always_comb begin
        logic [1:0] idx;
        w_win       = 2'd0;
        w_win_valid = 1'b0;
        idx         = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = r_ptr + 2'(k);
            if (!w_win_valid && req[idx]) begin
                w_win       = idx;
                w_win_valid = 1'b1;
            end
        end
    end

    // Operands come from the new winner in IDLE, or from the current owner
    // when a locked owner re-latches at the end of its access.
    assign w_src       = (r_state == ST_IDLE) ? w_win : r_grant;
    assign w_sel_addr  = addr_in[{w_src, 5'b00000} +: 32];
    assign w_sel_wdata = wdata_in[{w_src, 5'b00000} +: 32];
    assign w_last      = (r_state == ST_BUSY) && (r_cnt == '0);

`ifdef SHMEM_ARB_LOCK_EN
    assign w_extend = lock[r_grant] & req[r_grant];
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, w_sel_addr[31:ADDR_W]};
`else
    assign w_extend = 1'b0;
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, lock, w_sel_addr[31:ADDR_W]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd3;
            r_grant <= 2'd0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wd    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_grant <= w_win;
                        r_addr  <= w_sel_addr[ADDR_W-1:0];
                        r_wdata <= w_sel_wdata;
                        r_rd    <= rd_in[w_win];
                        r_wd    <= wd_in[w_win];
                        r_cnt   <= C_CNT_MAX;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        if (w_extend) begin
                            // Atomic extension: same owner, pointer untouched.
                            r_addr  <= w_sel_addr[ADDR_W-1:0];
                            r_wdata <= w_sel_wdata;
                            r_rd    <= rd_in[r_grant];
                            r_wd    <= wd_in[r_grant];
                            r_cnt   <= C_CNT_MAX;
                        end else begin
                            r_ptr   <= r_grant;
                            r_rd    <= 1'b0;
                            r_wd    <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr    = {{(32-ADDR_W){1'b0}}, r_addr};
    assign mem_wdata   = r_wdata;
    assign mem_rd      = r_rd;
    assign mem_wd      = r_wd;
    assign done        = w_last ? (4'b0001 << r_grant) : 4'b0000;
    assign stall       = req & ~done;
    assign rdata       = mem_rdata;
    assign shared_busy = (r_state == ST_BUSY);

endmodule
`default_nettype wire
